// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA timing generator. Emits fetch coordinates (x, y)
//            LAT enabled cycles ahead of hsync/vsync/sync_b/blank_b, so that
//            frame-buffer data with LAT cycles of read latency lines up with
//            the sync and blank outputs at the DAC.
// Ports    : vgaclk      - pixel clock
//            rst_n       - asynchronous active-low reset
//            en          - clock enable, low freezes all state
//            x, y        - fetch coordinates (registered counters)
//            hsync/vsync - syncs at HSYNC_POL/VSYNC_POL, delayed LAT cycles
//            sync_b      - composite sync, active low, delayed LAT cycles
//            blank_b     - high inside visible area, delayed LAT cycles
//            line_start  - x==0 while enabled
//            frame_start - x==0, y==0 while enabled
//            frame_cnt   - completed-frame count, wraps modulo 2**FCW
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int CW        = 10,
    parameter int HACTIVE   = 640,
    parameter int HFP       = 16,
    parameter int HSYN      = 96,
    parameter int HBP       = 48,
    parameter int VACTIVE   = 480,
    parameter int VFP       = 10,
    parameter int VSYN      = 2,
    parameter int VBP       = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int LAT       = 2,
    parameter int FCW       = 8
) (
    input  logic           vgaclk,
    input  logic           rst_n,
    input  logic           en,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           hsync,
    output logic           vsync,
    output logic           sync_b,
    output logic           blank_b,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);

    localparam int c_HMAX = HACTIVE + HFP + HSYN + HBP;
    localparam int c_VMAX = VACTIVE + VFP + VSYN + VBP;

    localparam logic [CW-1:0] c_HLAST = CW'(c_HMAX - 1);
    localparam logic [CW-1:0] c_VLAST = CW'(c_VMAX - 1);

    // Window bounds are one bit wider than the counters: an upper bound may
    // legitimately equal 2**CW when the trailing porch is zero.
    localparam logic [CW:0] c_HS_BEG = (CW+1)'(HACTIVE + HFP);
    localparam logic [CW:0] c_HS_END = (CW+1)'(HACTIVE + HFP + HSYN);
    localparam logic [CW:0] c_VS_BEG = (CW+1)'(VACTIVE + VFP);
    localparam logic [CW:0] c_VS_END = (CW+1)'(VACTIVE + VFP + VSYN);
    localparam logic [CW:0] c_HVIS   = (CW+1)'(HACTIVE);
    localparam logic [CW:0] c_VVIS   = (CW+1)'(VACTIVE);

    generate
        if (c_HMAX > 2**CW) begin : g_chk_hmax
            $error("vga_timing_gen: HMAX exceeds counter range 2**CW");
        end
        if (c_VMAX > 2**CW) begin : g_chk_vmax
            $error("vga_timing_gen: VMAX exceeds counter range 2**CW");
        end
        if (LAT > 8 || LAT < 0) begin : g_chk_lat
            $error("vga_timing_gen: LAT must be in 0..8");
        end
    endgenerate

    logic [CW-1:0]  r_x;
    logic [CW-1:0]  r_y;
    logic [FCW-1:0] r_frame_cnt;
    logic           w_x_last;
    logic           w_y_last;

    assign w_x_last = (r_x == c_HLAST);
    assign w_y_last = (r_y == c_VLAST);

    // End of line and end of frame resolve on one edge, so x, y and
    // frame_cnt never show an intermediate combination.
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
        end else if (en) begin
            if (w_x_last) begin
                r_x <= '0;
                if (w_y_last) begin
                    r_y         <= '0;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end else begin
                    r_y <= r_y + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    logic [CW:0] w_xe;
    logic [CW:0] w_ye;
    logic        w_hs_act;
    logic        w_vs_act;
    logic        w_vis;
    logic [2:0]  w_raw;
    logic [2:0]  w_tap;

    assign w_xe     = {1'b0, r_x};
    assign w_ye     = {1'b0, r_y};
    assign w_hs_act = (w_xe >= c_HS_BEG) && (w_xe < c_HS_END);
    assign w_vs_act = (w_ye >= c_VS_BEG) && (w_ye < c_VS_END);
    assign w_vis    = (w_xe < c_HVIS) && (w_ye < c_VVIS);
    assign w_raw    = {w_hs_act, w_vs_act, w_vis};

    // Delay line {hs, vs, vis}. Cleared stages decode to inactive sync and
    // blanked video, which is the fill seen for LAT cycles after reset.
    generate
        if (LAT == 0) begin : g_nopipe
            assign w_tap = w_raw;
        end else begin : g_pipe
            logic [2:0] r_pipe [LAT];

            always_ff @(posedge vgaclk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else if (en) begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < LAT; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_tap = r_pipe[LAT-1];
        end
    endgenerate

    assign hsync       = w_tap[2] ^ ~HSYNC_POL;
    assign vsync       = w_tap[1] ^ ~VSYNC_POL;
    assign sync_b      = ~(w_tap[2] | w_tap[1]);
    assign blank_b     = w_tap[0];

    // Strobes are aligned with the fetch coordinates, not the delayed outputs.
    assign line_start  = en && (r_x == '0);
    assign frame_start = en && (r_x == '0) && (r_y == '0);

    assign x           = r_x;
    assign y           = r_y;
    assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//==============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen. Three instances share
//            clock, reset and enable: default 640x480/LAT=2, inverted sync
//            polarity, and a small 8x6 LAT=0 configuration.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vga_timing_gen;

    logic vgaclk = 1'b0;
    logic rst_n  = 1'b0;
    logic en     = 1'b0;

    always #5 vgaclk = ~vgaclk;

    // Default instance
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;
    logic d_hs, d_vs, d_sb, d_bb, d_ls, d_fs;

    // Inverted polarity instance
    logic [9:0] p_x, p_y;
    logic [7:0] p_fc;
    logic p_hs, p_vs, p_sb, p_bb, p_ls, p_fs;

    // Small instance
    logic [3:0] s_x, s_y;
    logic [1:0] s_fc;
    logic s_hs, s_vs, s_sb, s_bb, s_ls, s_fs;

    vga_timing_gen u_def (
        .vgaclk(vgaclk), .rst_n(rst_n), .en(en),
        .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs), .sync_b(d_sb),
        .blank_b(d_bb), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_timing_gen #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_pol (
        .vgaclk(vgaclk), .rst_n(rst_n), .en(en),
        .x(p_x), .y(p_y), .hsync(p_hs), .vsync(p_vs), .sync_b(p_sb),
        .blank_b(p_bb), .line_start(p_ls), .frame_start(p_fs), .frame_cnt(p_fc)
    );

    vga_timing_gen #(
        .CW(4), .HACTIVE(4), .HFP(1), .HSYN(2), .HBP(1),
        .VACTIVE(3), .VFP(1), .VSYN(1), .VBP(1), .LAT(0), .FCW(2)
    ) u_sml (
        .vgaclk(vgaclk), .rst_n(rst_n), .en(en),
        .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs), .sync_b(s_sb),
        .blank_b(s_bb), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vgaclk);
        #2;
    endtask

    // Enable-gap vectors: en applied for the cycle, expected outputs before
    // that cycle's edge. Starts at x=0, y=1 of the default instance.
    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic       ls;
        logic       fs;
        logic       bb;
        logic       hs;
    } gap_vec_t;

    gap_vec_t gv [12];

    initial begin
        int guard;
        bit exp_hs, exp_bb;
        int sx, sy;

        gv[0]  = '{1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        gv[1]  = '{1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        gv[2]  = '{1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        gv[3]  = '{1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        gv[4]  = '{1'b1, 10'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        gv[5]  = '{1'b1, 10'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        gv[6]  = '{1'b0, 10'd3, 1'b0, 1'b0, 1'b1, 1'b1};
        gv[7]  = '{1'b0, 10'd3, 1'b0, 1'b0, 1'b1, 1'b1};
        gv[8]  = '{1'b0, 10'd3, 1'b0, 1'b0, 1'b1, 1'b1};
        gv[9]  = '{1'b1, 10'd3, 1'b0, 1'b0, 1'b1, 1'b1};
        gv[10] = '{1'b1, 10'd4, 1'b0, 1'b0, 1'b1, 1'b1};
        gv[11] = '{1'b1, 10'd5, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state with en low
        tick();
        tick();
        chk("rst_x",       32'(d_x),  32'd0);
        chk("rst_y",       32'(d_y),  32'd0);
        chk("rst_fc",      32'(d_fc), 32'd0);
        chk("rst_hsync",   32'(d_hs), 32'd1);
        chk("rst_vsync",   32'(d_vs), 32'd1);
        chk("rst_sync_b",  32'(d_sb), 32'd1);
        chk("rst_blank_b", 32'(d_bb), 32'd0);
        chk("rst_ls_en0",  32'(d_ls), 32'd0);
        chk("rst_fs_en0",  32'(d_fs), 32'd0);
        chk("rst_pol_hs",  32'(p_hs), 32'd0);
        chk("rst_pol_vs",  32'(p_vs), 32'd0);
        chk("rst_pol_sb",  32'(p_sb), 32'd1);

        // One full default line, enabled continuously
        rst_n = 1'b1;
        en    = 1'b1;
        #1;
        for (int n = 0; n < 800; n++) begin
            exp_bb = (n >= 2) && (n - 2 < 640);
            exp_hs = !((n >= 658) && (n < 754));
            chk("line_x",       32'(d_x),  32'(n));
            chk("line_y",       32'(d_y),  32'd0);
            chk("line_blank_b", 32'(d_bb), 32'(exp_bb));
            chk("line_hsync",   32'(d_hs), 32'(exp_hs));
            chk("line_vsync",   32'(d_vs), 32'd1);
            chk("line_sync_b",  32'(d_sb), 32'(exp_hs));
            chk("line_ls",      32'(d_ls), 32'(n == 0));
            chk("line_fs",      32'(d_fs), 32'(n == 0));
            chk("pol_hsync",    32'(p_hs), 32'(!exp_hs));
            chk("pol_vsync",    32'(p_vs), 32'd0);
            chk("pol_sync_b",   32'(p_sb), 32'(exp_hs));

            sx = n % 8;
            sy = (n / 8) % 6;
            chk("sml_x",       32'(s_x),  32'(sx));
            chk("sml_y",       32'(s_y),  32'(sy));
            chk("sml_fc",      32'(s_fc), 32'((n / 48) % 4));
            chk("sml_blank_b", 32'(s_bb), 32'((sx < 4) && (sy < 3)));
            chk("sml_hsync",   32'(s_hs), 32'(!((sx == 5) || (sx == 6))));
            chk("sml_vsync",   32'(s_vs), 32'(sy != 4));
            chk("sml_sync_b",  32'(s_sb), 32'(!((sx == 5) || (sx == 6) || (sy == 4))));
            chk("sml_fs",      32'(s_fs), 32'((sx == 0) && (sy == 0)));
            tick();
        end
        chk("line_wrap_x", 32'(d_x), 32'd0);
        chk("line_wrap_y", 32'(d_y), 32'd1);

        // Enable gaps
        for (int i = 0; i < 12; i++) begin
            en = gv[i].en;
            #1;
            chk("gap_x",       32'(d_x),  32'(gv[i].x));
            chk("gap_y",       32'(d_y),  32'd1);
            chk("gap_ls",      32'(d_ls), 32'(gv[i].ls));
            chk("gap_fs",      32'(d_fs), 32'(gv[i].fs));
            chk("gap_blank_b", 32'(d_bb), 32'(gv[i].bb));
            chk("gap_hsync",   32'(d_hs), 32'(gv[i].hs));
            tick();
        end

        // Async reset mid-line at x=300
        en    = 1'b1;
        guard = 0;
        while (d_x != 10'd300 && guard < 2000) begin
            tick();
            guard++;
        end
        chk("reach_x300", 32'(d_x), 32'd300);
        chk("pre_rst_blank_b", 32'(d_bb), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_x",       32'(d_x),  32'd0);
        chk("arst_y",       32'(d_y),  32'd0);
        chk("arst_fc",      32'(d_fc), 32'd0);
        chk("arst_blank_b", 32'(d_bb), 32'd0);
        chk("arst_hsync",   32'(d_hs), 32'd1);
        chk("arst_sml_fc",  32'(s_fc), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_fs",      32'(d_fs), 32'd1);
        chk("rel_blank_0", 32'(d_bb), 32'd0);
        tick();
        chk("rel_x1",      32'(d_x),  32'd1);
        chk("rel_blank_1", 32'(d_bb), 32'd0);
        tick();
        chk("rel_x2",      32'(d_x),  32'd2);
        chk("rel_blank_2", 32'(d_bb), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator that replaces the fixed 640x480 controller.
- Produces pixel coordinates (x, y) one read-latency ahead of the sync and blank outputs, so that frame-buffer data with LAT cycles of read latency arrives aligned with hsync, vsync and blank_b at the DAC.
- Adds the following over the fixed controller: clock enable, configurable sync polarity, frame_start and line_start strobes, and a frame counter.
- Sits between the vgaclk domain and the frame-buffer read port / video DAC.

Parameters:
- CW, 10: coordinate counter width.
- HACTIVE, 640: visible pixels per line.
- HFP, 16: horizontal front porch.
- HSYN, 96: hsync pulse width.
- HBP, 48: horizontal back porch.
- VACTIVE, 480: visible lines.
- VFP, 10: vertical front porch.
- VSYN, 2: vsync pulse width.
- VBP, 33: vertical back porch.
- HSYNC_POL, 0: asserted level of hsync (0 = active low).
- VSYNC_POL, 0: asserted level of vsync.
- LAT, 2: cycles of delay from x/y to hsync/vsync/sync_b/blank_b (0..8).
- FCW, 8: frame counter width.

Ports:
- vgaclk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  clock enable; low freezes all state.
- x  out  CW  horizontal counter (fetch coordinate).
- y  out  CW  vertical counter (fetch coordinate).
- hsync  out  1  horizontal sync at HSYNC_POL, delayed LAT.
- vsync  out  1  vertical sync at VSYNC_POL, delayed LAT.
- sync_b  out  1  composite sync, active low, polarity-independent, delayed LAT.
- blank_b  out  1  high inside the visible area, delayed LAT.
- line_start  out  1  high while x==0 and en==1.
- frame_start  out  1  high while x==0, y==0 and en==1.
- frame_cnt  out  FCW  completed-frame count.

Behaviour:
- Derived values: HMAX = HACTIVE+HFP+HSYN+HBP; VMAX = VACTIVE+VFP+VSYN+VBP.
- Elaboration error if HMAX > 2**CW, VMAX > 2**CW, or LAT > 8.
- Single clock vgaclk. rst_n is asynchronous assert and synchronous deassert from the system's point of view; every flop clears immediately when rst_n=0.
- Reset values:
  - x=0, y=0, frame_cnt=0.
  - Delay-pipe stages all hold: hsync=!HSYNC_POL, vsync=!VSYNC_POL, sync_b=1, blank_b=0.
  - line_start and frame_start follow their combinational definitions (high once en=1).
- Counters (registered, advance only on vgaclk edges with en=1):
  - x increments each cycle.
  - At x==HMAX-1: x<=0 and y increments.
  - At x==HMAX-1 and y==VMAX-1: y<=0 and frame_cnt increments, wrapping modulo 2**FCW.
- Raw timing, computed from the current x, y:
  - hs_act = (x >= HACTIVE+HFP) && (x < HACTIVE+HFP+HSYN).
  - vs_act = (y >= VACTIVE+VFP) && (y < VACTIVE+VFP+VSYN).
  - vis = (x < HACTIVE) && (y < VACTIVE).
- Delay pipe:
  - LAT-stage shift register carrying {hs_act, vs_act, vis}; shifts only when en=1.
  - Outputs: hsync = tap XOR !HSYNC_POL; vsync = tap XOR !VSYNC_POL; sync_b = !(hs_tap | vs_tap); blank_b = vis_tap.
  - LAT=0: the outputs are combinational from the current counters; no pipe flops exist.
- Latency: the sync/blank state for coordinate (X,Y) appears LAT enabled cycles after x,y showed (X,Y).
- Strobes: line_start and frame_start are combinational on the registered counters and en, aligned with x/y (not delayed). With en=0 both are low.
- en=0: counters, pipe and frame_cnt all hold; the delayed outputs keep their last values.
- Reset mid-frame: all state returns to reset values on the same cycle. After release, with en=1, the first cycle shows x=0, y=0 and frame_start=1. The delayed outputs show the blanked, inactive-sync reset fill for LAT cycles.
- Simultaneous end-of-line and end-of-frame: a single edge updates x, y and frame_cnt together; no intermediate state is visible.

Test Plan:
- Reset then en=1 with defaults, LAT=2:
  - cycle 0: x=0, y=0, frame_start=1, line_start=1, blank_b=0 (pipe fill).
  - cycle 2: blank_b=1.
  - hsync=1 until it goes low at cycle 658 (x=656 + 2), stays low for 96 cycles, returns high at cycle 754.
- Full frame: after 420000 enabled cycles, x=0, y=0, frame_start=1, frame_cnt=1. vsync is low for exactly 1600 cycles, starting 2 cycles after y=490, x=0.
- Enable gaps: toggle en 0/1 every 3 cycles across a line. Position and timing are unchanged when measured in enabled cycles; no outputs change during en=0; strobes are low during en=0.
- Polarity: HSYNC_POL=1, VSYNC_POL=1. hsync is high only during the pulse window, vsync likewise, and sync_b is identical to the default-polarity run.
- Async reset: assert rst_n=0 at x=300, y=200, mid-clock. Outputs clear before the next edge to x=0, y=0, frame_cnt=0, blank_b=0, hsync=1.
- Small config (HACTIVE=4, HFP=1, HSYN=2, HBP=1, VACTIVE=3, VFP=1, VSYN=1, VBP=1, LAT=0, FCW=2):
  - HMAX=8, VMAX=6; frame_cnt wraps 3 to 0 after 4 frames (192 cycles).
  - blank_b=vis with the same timing as x; hsync low at x=5,6.
